rgb2ycbcr_pipe: RTL

//  Parametrised RGB -> Y/Cb/Cr converter for the HDMI video path; successor of the luma-only block.

---
 rtl/rgb2ycbcr_pipe_if.sv | 32 +++
 rtl/rgb2ycbcr_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_pipe_if.sv
// Pixel-stream bundle for rgb2ycbcr_pipe: RGB input side and Y/Cb/Cr output side.
// The master is the video source/sink, and the slave is the converter.
interface rgb2ycbcr_pipe_if #(
  parameter int COLORDEPTH = 8
);
  logic                  mode_i;
  logic [COLORDEPTH-1:0] red_i;
  logic [COLORDEPTH-1:0] green_i;
  logic [COLORDEPTH-1:0] blue_i;
  logic                  dv_i;
  logic                  hs_i;
  logic                  vs_i;

  logic [COLORDEPTH-1:0] y_o;
  logic [COLORDEPTH-1:0] cb_o;
  logic [COLORDEPTH-1:0] cr_o;
  logic                  dv_o;
  logic                  hs_o;
  logic                  vs_o;
  logic                  line_end_o;
  logic                  mode_o;

  modport master (
    output mode_i, red_i, green_i, blue_i, dv_i, hs_i, vs_i,
    input  y_o, cb_o, cr_o, dv_o, hs_o, vs_o, line_end_o, mode_o
  );

  modport slave (
    input  mode_i, red_i, green_i, blue_i, dv_i, hs_i, vs_i,
    output y_o, cb_o, cr_o, dv_o, hs_o, vs_o, line_end_o, mode_o
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// Five-stage RGB -> Y/Cb/Cr converter with a BT.601/BT.709 coefficient set chosen once per frame.
// The outputs are rounded and saturated, and the sync/valid flags are delayed to match the pixel data.
module rgb2ycbcr_pipe #(
  parameter int COLORDEPTH = 8,
  parameter int FRAC       = 17
) (
  input logic             clk,
  input logic             rst_n,
  rgb2ycbcr_pipe_if.slave bus
);
  localparam int CD = COLORDEPTH;
  localparam int PW = CD + 1 + 18;
  localparam int SW = CD + FRAC + 3;

  typedef logic signed [17:0]   coef_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t RND  = sum_t'(1) <<< (FRAC - 1);
  localparam sum_t OFS  = sum_t'(1) <<< (CD - 1 + FRAC);
  localparam sum_t MAXV = sum_t'((1 << CD) - 1);

  // Order: {Y, Cb, Cr} x {R, G, B}, Q1.17 reference values.
  localparam int K601 [9] = '{39191, 76939, 14942, -22116, -43420, 65536, 65536, -54878, -10658};
  localparam int K709 [9] = '{27866, 93743,  9463, -15017, -50519, 65536, 65536, -59527,  -6009};

  // Rescale a Q1.17 coefficient to Q1.FRAC. FRAC values above 17 do not fit the 18-bit format.
  function automatic coef_t scale(input int c17);
    int sh;
    int v;
    sh = 17 - FRAC;
    if (sh <= 0) v = c17;
    else         v = (c17 + (1 <<< (sh - 1))) >>> sh;
    return coef_t'(v);
  endfunction

  logic vs_prev, armed, active_mode;
  logic vs_rise, mode_eff;

  // armed blocks the first post-reset cycle, so a vs already high at release is not taken as an edge.
  assign vs_rise  = armed & bus.vs_i & ~vs_prev;
  assign mode_eff = vs_rise ? bus.mode_i : active_mode;

  logic [CD-1:0] comp1 [3];
  logic [3:0]    dv_p, hs_p, vs_p, md_p;
  coef_t         k [9];
  prod_t         prod [9];
  sum_t          part_rg [3];
  sum_t          part_b [3];
  sum_t          sum4 [3];
  sum_t          shifted [3];
  logic [CD-1:0] sat [3];

  logic [CD-1:0] y_q, cb_q, cr_q;
  logic          dv_q, hs_q, vs_q, le_q, md_q;

  always_comb begin
    for (int i = 0; i < 9; i++) k[i] = md_p[0] ? scale(K709[i]) : scale(K601[i]);
  end

  // NOTE: each combinational output gets a default before the if-chain, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      shifted[c] = sum4[c] >>> FRAC;
      sat[c]     = '0;
      if (shifted[c] > MAXV)     sat[c] = MAXV[CD-1:0];
      else if (shifted[c] >= 0)  sat[c] = shifted[c][CD-1:0];
    end
  end

  // NOTE: every pipeline register is a flop rather than RAM, so all of them clear on reset.
  // A mid-frame reset therefore flushes the whole pipe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev     <= 1'b0;
      armed       <= 1'b0;
      active_mode <= 1'b0;
      dv_p        <= '0;
      hs_p        <= '0;
      vs_p        <= '0;
      md_p        <= '0;
      for (int j = 0; j < 3; j++) comp1[j] <= '0;
      for (int i = 0; i < 9; i++) prod[i] <= '0;
      for (int c = 0; c < 3; c++) begin
        part_rg[c] <= '0;
        part_b[c]  <= '0;
        sum4[c]    <= '0;
      end
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
      dv_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      le_q <= 1'b0;
      md_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each stage reading the previous cycle's values.
      vs_prev <= bus.vs_i;
      armed   <= 1'b1;
      if (vs_rise) active_mode <= bus.mode_i;

      comp1[0] <= bus.red_i;
      comp1[1] <= bus.green_i;
      comp1[2] <= bus.blue_i;
      dv_p     <= {dv_p[2:0], bus.dv_i};
      hs_p     <= {hs_p[2:0], bus.hs_i};
      vs_p     <= {vs_p[2:0], bus.vs_i};
      md_p     <= {md_p[2:0], mode_eff};

      for (int i = 0; i < 9; i++)
        prod[i] <= prod_t'($signed({1'b0, comp1[i % 3]})) * prod_t'(k[i]);

      // The chroma offset is added together with the rounding constant, in the same adder.
      for (int c = 0; c < 3; c++) begin
        part_rg[c] <= sum_t'(prod[3*c]) + sum_t'(prod[3*c+1]);
        part_b[c]  <= sum_t'(prod[3*c+2]);
        sum4[c]    <= part_rg[c] + part_b[c] + ((c == 0) ? RND : RND + OFS);
      end

      y_q  <= sat[0];
      cb_q <= sat[1];
      cr_q <= sat[2];
      dv_q <= dv_p[3];
      hs_q <= hs_p[3];
      vs_q <= vs_p[3];
      md_q <= md_p[3];
      le_q <= dv_q & ~dv_p[3];
    end
  end

  assign bus.y_o        = y_q;
  assign bus.cb_o       = cb_q;
  assign bus.cr_o       = cr_q;
  assign bus.dv_o       = dv_q;
  assign bus.hs_o       = hs_q;
  assign bus.vs_o       = vs_q;
  assign bus.line_end_o = le_q;
  assign bus.mode_o     = md_q;
endmodule
